// File: rtl/led_loop_pkg.sv
// Shared mode encoding and command field layout
// for the LED pattern engine.
package led_loop_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC  = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_CHASE_L = 2'd2,
        MODE_CHASE_R = 2'd3
    } mode_e;

    localparam int CMD_MODE_LSB = 0;
    localparam int CMD_MODE_W   = 2;
    localparam int CMD_RATE_LSB = 2;
    localparam int CMD_RATE_W   = 4;

    function automatic mode_e next_mode(input mode_e m);
        logic [1:0] t;
        t = m + 2'd1;
        return mode_e'(t);
    endfunction

endpackage

// File: rtl/gpio_sync_debounce.sv
// Two-flop synchronizer with optional stable-count debouncer.
// DB_CYCLES of zero leaves only the synchronizer.
module gpio_sync_debounce #(
    parameter int W         = 1,
    parameter int DB_CYCLES = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sync1_q, sync1_d;
    logic [W-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = d_i;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    generate
        if (DB_CYCLES == 0) begin : g_sync_only
            assign q_o = sync2_q;
        end else begin : g_debounce
            localparam int CNT_W = $clog2(DB_CYCLES + 1);

            logic [W-1:0]     db_q, db_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;

            // Level flips only after DB_CYCLES consecutive differing samples.
            always_comb begin
                db_d  = db_q;
                cnt_d = cnt_q;
                if (sync2_q == db_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                    db_d  = sync2_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    db_q  <= '0;
                    cnt_q <= '0;
                end else begin
                    db_q  <= db_d;
                    cnt_q <= cnt_d;
                end
            end

            assign q_o = db_q;
        end
    endgenerate

endmodule

// File: rtl/led_loop_ctrl.sv
// LED pattern engine written by the Pi over a strobed GPIO bus,
// with a local mode button and a programmable step rate.
module led_loop_ctrl #(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int DB_CYCLES   = 1_000_000,
    parameter int BUS_W       = 8,
    parameter int NUM_LEDS    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BUS_W-1:0]    gpio_i,
    input  logic                strb_i,
    input  logic                sel_i,
    input  logic                btn_i,
    output logic [NUM_LEDS-1:0] led_o,
    output logic                tick_o,
    output logic                sec_o,
    output logic                btn_o,
    output logic [1:0]          mode_o
);

    import led_loop_pkg::*;

    localparam int TICK_W = (TICK_CYCLES > 1) ?
                            $clog2(TICK_CYCLES) : 1;

    logic [BUS_W-1:0]    gpio_s;
    logic                strb_s;
    logic                sel_s;
    logic                btn_s;
    logic [NUM_LEDS-1:0] pat_in;

    gpio_sync_debounce #(.W(BUS_W), .DB_CYCLES(0)) u_gpio_sync (
        .clk (clk),
        .rst (rst),
        .d_i (gpio_i),
        .q_o (gpio_s)
    );

    gpio_sync_debounce #(.W(1), .DB_CYCLES(0)) u_strb_sync (
        .clk (clk),
        .rst (rst),
        .d_i (strb_i),
        .q_o (strb_s)
    );

    gpio_sync_debounce #(.W(1), .DB_CYCLES(0)) u_sel_sync (
        .clk (clk),
        .rst (rst),
        .d_i (sel_i),
        .q_o (sel_s)
    );

    gpio_sync_debounce #(.W(1), .DB_CYCLES(DB_CYCLES)) u_btn_db (
        .clk (clk),
        .rst (rst),
        .d_i (btn_i),
        .q_o (btn_s)
    );

    generate
        if (NUM_LEDS <= BUS_W) begin : g_pat_trunc
            assign pat_in = gpio_s[NUM_LEDS-1:0];
        end else begin : g_pat_ext
            assign pat_in = {{(NUM_LEDS - BUS_W){1'b0}}, gpio_s};
        end
    endgenerate

    logic                strb_prev_q, strb_prev_d;
    logic                btn_prev_q, btn_prev_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic                sec_q, sec_d;
    logic [3:0]          step_cnt_q, step_cnt_d;
    mode_e               mode_q, mode_d;
    logic [3:0]          rate_q, rate_d;
    logic [NUM_LEDS-1:0] pattern_q, pattern_d;
    logic [NUM_LEDS-1:0] rot_q, rot_d;
    logic                phase_q, phase_d;
    logic [NUM_LEDS-1:0] led_q, led_d;

    logic wr, data_wr, cmd_wr, btn_rise, tick, step;

    always_comb begin
        wr       = strb_s & ~strb_prev_q;
        data_wr  = wr & ~sel_s;
        cmd_wr   = wr & sel_s;
        btn_rise = btn_s & ~btn_prev_q;
        tick     = (tick_cnt_q == TICK_W'(TICK_CYCLES - 1));
        step     = tick && (step_cnt_q == rate_q);
    end

    always_comb begin
        strb_prev_d = strb_s;
        btn_prev_d  = btn_s;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + TICK_W'(1);
        sec_d       = sec_q ^ tick;
        step_cnt_d  = step_cnt_q;
        mode_d      = mode_q;
        rate_d      = rate_q;
        pattern_d   = pattern_q;
        rot_d       = rot_q;
        phase_d     = phase_q;

        if (tick) begin
            step_cnt_d = step ? 4'd0 : step_cnt_q + 4'd1;
        end

        if (step) begin
            unique case (mode_q)
                MODE_STATIC:  ;
                MODE_BLINK:   phase_d = ~phase_q;
                MODE_CHASE_L: rot_d = {rot_q[NUM_LEDS-2:0],
                                       rot_q[NUM_LEDS-1]};
                MODE_CHASE_R: rot_d = {rot_q[0],
                                       rot_q[NUM_LEDS-1:1]};
            endcase
        end

        // A fresh pattern replaces any rotation from this cycle's step.
        if (data_wr) begin
            pattern_d = pat_in;
            rot_d     = pat_in;
        end

        // Command beats a coincident button edge; that edge is lost.
        if (cmd_wr) begin
            mode_d     = mode_e'(gpio_s[CMD_MODE_LSB +: CMD_MODE_W]);
            rate_d     = gpio_s[CMD_RATE_LSB +: CMD_RATE_W];
            rot_d      = pattern_d;
            phase_d    = 1'b0;
            step_cnt_d = 4'd0;
        end else if (btn_rise) begin
            mode_d     = next_mode(mode_q);
            rot_d      = pattern_d;
            phase_d    = 1'b0;
            step_cnt_d = 4'd0;
        end
    end

    always_comb begin
        led_d = '0;
        unique case (mode_q)
            MODE_STATIC:  led_d = pattern_q;
            MODE_BLINK:   led_d = phase_q ? pattern_q : '0;
            MODE_CHASE_L: led_d = rot_q;
            MODE_CHASE_R: led_d = rot_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            strb_prev_q <= 1'b0;
            btn_prev_q  <= 1'b0;
            tick_cnt_q  <= '0;
            sec_q       <= 1'b0;
            step_cnt_q  <= 4'd0;
            mode_q      <= MODE_CHASE_L;
            rate_q      <= 4'd0;
            pattern_q   <= NUM_LEDS'(1);
            rot_q       <= NUM_LEDS'(1);
            phase_q     <= 1'b0;
            led_q       <= '0;
        end else begin
            strb_prev_q <= strb_prev_d;
            btn_prev_q  <= btn_prev_d;
            tick_cnt_q  <= tick_cnt_d;
            sec_q       <= sec_d;
            step_cnt_q  <= step_cnt_d;
            mode_q      <= mode_d;
            rate_q      <= rate_d;
            pattern_q   <= pattern_d;
            rot_q       <= rot_d;
            phase_q     <= phase_d;
            led_q       <= led_d;
        end
    end

    assign led_o  = led_q;
    assign tick_o = tick;
    assign sec_o  = sec_q;
    assign btn_o  = btn_s;
    assign mode_o = mode_q;

endmodule

// File: tb/tb_led_loop_ctrl.sv
// Directed bench for led_loop_ctrl with a short tick
// and debounce window.
module tb_led_loop_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] gpio = 8'h00;
    logic       strb = 1'b0;
    logic       sel = 1'b0;
    logic       btn = 1'b0;
    logic [7:0] led;
    logic       tick;
    logic       sec;
    logic       btn_db;
    logic [1:0] mode;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int u, p, c;

    led_loop_ctrl #(
        .TICK_CYCLES (10),
        .DB_CYCLES   (4),
        .BUS_W       (8),
        .NUM_LEDS    (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .gpio_i (gpio),
        .strb_i (strb),
        .sel_i  (sel),
        .btn_i  (btn),
        .led_o  (led),
        .tick_o (tick),
        .sec_o  (sec),
        .btn_o  (btn_db),
        .mode_o (mode)
    );

    always #5 clk = ~clk;

    // Posedges since reset release; the DUT tick counter equals cyc % 10.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected $finish");
        $fatal(1);
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Aligns to cyc%10==0; returns at the negedge after the register update.
    task automatic strobe(input logic s, input logic [7:0] d,
                          output int upd);
        while (cyc % 10 != 0) @(negedge clk);
        gpio = d;
        sel  = s;
        wait_cyc(3);
        strb = 1'b1;
        wait_cyc(3);
        upd = cyc;
    endtask

    task automatic unstrobe();
        strb = 1'b0;
        wait_cyc(3);
    endtask

    initial begin
        wait_cyc(3);
        check("rst_led", led, 8'h00);
        check("rst_tick", tick, 1'b0);
        check("rst_sec", sec, 1'b0);
        check("rst_btn", btn_db, 1'b0);
        check("rst_mode", mode, 2'd2);

        rst = 1'b0;
        wait_cyc(1);
        check("t1_led_first", led, 8'h01);
        wait_until(8);
        check("t1_tick_lo", tick, 1'b0);
        wait_until(9);
        check("t1_tick_hi", tick, 1'b1);
        wait_until(10);
        check("t1_tick_one", tick, 1'b0);
        check("t1_sec_hi", sec, 1'b1);
        check("t1_led_hold", led, 8'h01);
        wait_until(11);
        check("t1_led_02", led, 8'h02);
        for (int k = 2; k <= 8; k++) begin
            logic [7:0] e;
            e = 8'(1 << (k % 8));
            wait_until(10 * k + 1);
            check("t1_chase", led, e);
            if (k == 2) check("t1_sec_lo", sec, 1'b0);
        end

        strobe(1'b0, 8'hA5, u);
        unstrobe();
        strobe(1'b1, 8'h00, u);
        check("t2_mode", mode, 2'd0);
        wait_until(u + 1);
        check("t2_led", led, 8'hA5);
        unstrobe();
        for (int i = 1; i <= 10; i++) begin
            wait_until(u + 1 + 10 * i);
            check("t2_static", led, 8'hA5);
        end

        strobe(1'b0, 8'h3C, u);
        unstrobe();
        strobe(1'b1, 8'h05, u);
        check("t3_mode", mode, 2'd1);
        wait_until(u + 1);
        check("t3_off0", led, 8'h00);
        unstrobe();
        wait_until(u + 14);
        check("t3_off1", led, 8'h00);
        wait_until(u + 15);
        check("t3_on0", led, 8'h3C);
        wait_until(u + 34);
        check("t3_on1", led, 8'h3C);
        wait_until(u + 35);
        check("t3_off2", led, 8'h00);
        wait_until(u + 55);
        check("t3_on2", led, 8'h3C);

        strobe(1'b0, 8'h81, u);
        unstrobe();
        strobe(1'b1, 8'h03, u);
        check("t4_mode", mode, 2'd3);
        wait_until(u + 1);
        check("t4_81", led, 8'h81);
        unstrobe();
        wait_until(u + 4);
        check("t4_81_hold", led, 8'h81);
        wait_until(u + 5);
        check("t4_C0", led, 8'hC0);
        wait_until(u + 15);
        check("t4_60", led, 8'h60);
        wait_until(u + 25);
        check("t4_30", led, 8'h30);

        strobe(1'b1, 8'hC2, u);
        check("t5_cmd_hibits", mode, 2'd2);
        wait_until(u + 1);
        check("t5_rot_reload", led, 8'h81);
        unstrobe();
        wait_until(u + 5);
        check("t5_rate0_rotl", led, 8'h03);

        btn = 1'b1;
        wait_cyc(2);
        btn = 1'b0;
        wait_cyc(10);
        check("t5_glitch_mode", mode, 2'd2);
        check("t5_glitch_btn", btn_db, 1'b0);

        p = cyc;
        btn = 1'b1;
        wait_until(p + 5);
        check("t5_btn_early", btn_db, 1'b0);
        wait_until(p + 6);
        check("t5_btn_hi", btn_db, 1'b1);
        check("t5_mode_pre", mode, 2'd2);
        wait_until(p + 7);
        check("t5_mode_2to3", mode, 2'd3);
        wait_until(p + 10);
        btn = 1'b0;
        wait_until(p + 20);
        check("t5_btn_lo", btn_db, 1'b0);

        p = cyc;
        btn = 1'b1;
        wait_until(p + 7);
        check("t5_mode_3to0", mode, 2'd0);
        wait_until(p + 10);
        btn = 1'b0;
        wait_until(p + 20);

        gpio = 8'h03;
        sel  = 1'b1;
        wait_cyc(3);
        c = cyc;
        btn = 1'b1;
        wait_until(c + 4);
        strb = 1'b1;
        wait_until(c + 7);
        check("t6_cmd_wins", mode, 2'd3);
        wait_until(c + 14);
        check("t6_edge_dropped", mode, 2'd3);
        strb = 1'b0;
        btn  = 1'b0;
        wait_cyc(12);

        rst = 1'b1;
        wait_cyc(1);
        check("t6_rst_led", led, 8'h00);
        check("t6_rst_tick", tick, 1'b0);
        check("t6_rst_sec", sec, 1'b0);
        check("t6_rst_btn", btn_db, 1'b0);
        check("t6_rst_mode", mode, 2'd2);
        rst = 1'b0;
        wait_cyc(1);
        check("t6_rst_pattern", led, 8'h01);

        strobe(1'b0, 8'h00, u);
        wait_until(u + 1);
        check("bnd_zero", led, 8'h00);
        unstrobe();
        wait_until(u + 12);
        check("bnd_zero_hold", led, 8'h00);

        strobe(1'b0, 8'hFF, u);
        wait_until(u + 1);
        check("bnd_ones", led, 8'hFF);
        unstrobe();
        wait_until(u + 12);
        check("bnd_ones_hold", led, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
